// File: rtl/dmem_responder.sv
// ============================================================================
// Module   : dmem_responder
// Brief    : Word-organised data RAM behind a valid/ready load/store handshake
//            with programmable wait states and RV32I lane/extension handling.
//            Optional access-fault reporting under macro DMEM_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
`ifdef DMEM_ERR_EN
  output logic        rsp_err,
`endif
  output logic        busy
);

  localparam int              c_AW        = $clog2(DEPTH_WORDS);
  localparam int              c_CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_WAIT_INIT = (WAIT_CYCLES > 0) ? c_CW'(WAIT_CYCLES - 1) : '0;
  localparam logic [31:0]     c_SPAN      = 32'(4 * DEPTH_WORDS);

  localparam logic [1:0] c_S_IDLE   = 2'd0;
  localparam logic [1:0] c_S_WAIT   = 2'd1;
  localparam logic [1:0] c_S_ACCESS = 2'd2;
  localparam logic [1:0] c_S_RESP   = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [c_CW-1:0] r_cnt;
  logic [31:0]     r_addr;
  logic            r_we;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic [31:0]     w_off;
  logic [c_AW-1:0] w_idx;
  logic [1:0]      w_lane;
  logic [31:0]     w_word;
  logic [31:0]     w_sh;
  logic [15:0]     w_half;
  logic [31:0]     w_load;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic            w_fault;
  logic            w_unused;

  assign w_accept = req_valid && (r_state == c_S_IDLE);
  assign w_off    = r_addr - ADDR_BASE;
  assign w_idx    = w_off[c_AW+1:2];
  assign w_lane   = r_addr[1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE:   if (req_valid) w_next = (WAIT_CYCLES == 0) ? c_S_ACCESS : c_S_WAIT;
      c_S_WAIT:   if (r_cnt == '0) w_next = c_S_ACCESS;
      c_S_ACCESS: w_next = c_S_RESP;
      c_S_RESP:   if (rsp_ready) w_next = c_S_IDLE;
      default:    w_next = c_S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == c_S_IDLE);
    rsp_valid = (r_state == c_S_RESP);
    busy      = (r_state != c_S_IDLE);
  end

  // ------------------------------------------------------- lane handling
`ifdef DMEM_ERR_EN
  assign w_fault = ((r_size == 2'b01) && r_addr[0])
                || ((r_size == 2'b10) && (r_addr[1:0] != 2'b00))
                ||  (r_size == 2'b11)
                ||  (w_off >= c_SPAN);
`else
  assign w_fault = 1'b0;
`endif

  assign w_word = r_mem[w_idx];
  assign w_sh   = w_word >> {w_lane, 3'b000};
  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    case (r_size)
      2'b00:   w_load = r_unsigned ? {24'b0, w_sh[7:0]} : {{24{w_sh[7]}}, w_sh[7:0]};
      2'b01:   w_load = r_unsigned ? {16'b0, w_half}    : {{16{w_half[15]}}, w_half};
      default: w_load = w_word;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick placement
  always_comb begin
    case (r_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_cnt      <= c_WAIT_INIT;
        r_addr     <= req_addr;
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_wdata    <= req_wdata;
      end else if ((r_state == c_S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_CW'(1);
      end
      if (r_state == c_S_ACCESS)
        r_rdata <= (r_we || w_fault) ? 32'h0 : w_load;
    end
  end

`ifdef DMEM_ERR_EN
  logic r_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          r_err <= 1'b0;
    else if (r_state == c_S_ACCESS)   r_err <= w_fault;
  end
  assign rsp_err = r_err;
`endif

  // RAM contents are deliberately left without reset
  always_ff @(posedge clk) begin
    if ((r_state == c_S_ACCESS) && r_we && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign w_unused  = ^{w_off, w_sh[31:8]};

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder against a byte-array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  localparam int          DEPTH = 256;
  localparam int          WAITC = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_ready, rsp_valid, busy;
  logic [31:0] rsp_rdata;
  logic        err_obs;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mb [4*DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
`ifdef DMEM_ERR_EN
    .rsp_err(err_obs),
`endif
    .busy(busy)
  );

`ifndef DMEM_ERR_EN
  assign err_obs = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-addressed reference: each access touches 1/2/4 consecutive bytes
  function automatic void model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er);
    logic [31:0] off;
    int unsigned base, start, n;
    logic [31:0] v;
    off = addr - BASE;
    er  = ERR_EN && (((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'd0)) ||
                     (size == 2'd3) || (off >= 32'(4*DEPTH)));
    base  = ((off / 4) % DEPTH) * 4;
    n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    start = base + ((n == 1) ? int'(addr[1:0]) : (n == 2) ? (addr[1] ? 2 : 0) : 0);
    rd = 32'h0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < n; i++) mb[start+i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mb[start+i]) << (8*i));
      if (!uns && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rd = v;
    end
  endfunction

  function automatic logic [31:0] model_word(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input int hold,
                      output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    logic        exp_er;
    int          lat, bad;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata; rsp_ready = (hold == 0);
    check("accept_ready", 32'(req_ready), 32'd1);
    model(we, addr, size, uns, wdata, exp_rd, exp_er);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    lat = 0; bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (req_ready) bad++;
    end while (!rsp_valid && lat < 20);
    check("latency", 32'(lat), 32'(WAITC + 2));
    check("busy_ready_low", 32'(bad), 32'd0);
    if (hold > 0) begin
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_rdata", rsp_rdata, exp_rd);
        check("hold_no_accept", 32'(req_ready), 32'd0);
        @(negedge clk);
      end
      rsp_ready = 1'b1;
    end
    rd = rsp_rdata; er = err_obs;
    check("rdata", rd, exp_rd);
    check("err", 32'(er), 32'(exp_er));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] rd, w, pre;
    logic        er;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      dut.r_mem[i] = w;
      for (int k = 0; k < 4; k++) mb[4*i+k] = w[8*k +: 8];
    end
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_obs), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Reset during WAIT of a store: the store must never land
    pre = model_word(4);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2; req_wdata = 32'hDEADBEEF;
    @(posedge clk); #1; req_valid = 1'b0;
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    rst = 1'b1; #1;
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    @(negedge clk); rst = 1'b0;
    check("after_rst_ready", 32'(req_ready), 32'd1);
    xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check("lw_after_rst", rd, pre);

    xact(1'b1, 32'h0, 2'd2, 1'b0, 32'h8899AABB, 0, rd, er);
    check("sw_rdata_zero", rd, 32'h0);
    xact(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check("lw0", rd, 32'h8899AABB);

    xact(1'b1, 32'h4, 2'd2, 1'b0, 32'h11223344, 0, rd, er);
    xact(1'b1, 32'h5, 2'd0, 1'b0, 32'h000000F0, 0, rd, er);
    xact(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check("sb_merge", rd, 32'h1122F044);
    xact(1'b0, 32'h5, 2'd0, 1'b0, 32'h0, 0, rd, er);
    check("lb", rd, 32'hFFFFFFF0);
    xact(1'b0, 32'h5, 2'd0, 1'b1, 32'h0, 0, rd, er);
    check("lbu", rd, 32'h000000F0);

    xact(1'b1, 32'h8, 2'd2, 1'b0, 32'h80017FFF, 0, rd, er);
    xact(1'b0, 32'hA, 2'd1, 1'b0, 32'h0, 0, rd, er);
    check("lh_hi", rd, 32'hFFFF8001);
    xact(1'b0, 32'hA, 2'd1, 1'b1, 32'h0, 0, rd, er);
    check("lhu_hi", rd, 32'h00008001);
    xact(1'b0, 32'h8, 2'd1, 1'b0, 32'h0, 0, rd, er);
    check("lh_lo", rd, 32'h00007FFF);

    xact(1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 5, rd, er);
    check("held_rsp", rd, 32'h80017FFF);

    xact(1'b1, 32'(4*DEPTH), 2'd2, 1'b0, 32'hCAFEF00D, 0, rd, er);
    xact(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 0, rd, er);
`ifdef DMEM_ERR_EN
    check("oob_sw_blocked", rd, 32'h8899AABB);
    xact(1'b0, 32'h2, 2'd2, 1'b0, 32'h0, 0, rd, er);
    check("misaligned_err", 32'(er), 32'd1);
    check("misaligned_rdata", rd, 32'h0);
`else
    check("oob_sw_wraps", rd, 32'hCAFEF00D);
`endif

    for (int t = 0; t < 200; t++) begin
      xact(1'($urandom), 32'($urandom_range(0, 8*DEPTH - 1)), 2'($urandom), 1'($urandom),
           $urandom, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, rd, er);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
